// File: rtl/game_flow_ctrl.sv
// Screen sequencer for the dino-run game: TITLE -> RUN -> DEAD -> RUN.
// Gates the title banner, pulses the object reset at game start and keeps the BCD score.
module game_flow_ctrl #(
    parameter int unsigned BlinkFrames = 30,
    parameter int unsigned ScoreFrames = 6,
    parameter int unsigned DeadFrames  = 60
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        frame_i,
    input  logic        start_btn_i,
    input  logic        collision_i,
    input  logic        title_pixel_i,
    output logic        title_pixel_o,
    output logic [1:0]  state_o,
    output logic        game_run_o,
    output logic        game_reset_o,
    output logic [15:0] score_o
);

    typedef enum logic [1:0] {
        ST_TITLE = 2'd0,
        ST_RUN   = 2'd1,
        ST_DEAD  = 2'd2
    } state_t;

    localparam logic [7:0] BLINK_LAST = 8'(BlinkFrames - 1);
    localparam logic [7:0] SCORE_LAST = 8'(ScoreFrames - 1);
    localparam logic [7:0] DEAD_LAST  = 8'(DeadFrames);

    state_t      state;
    logic [7:0]  frame_cnt;
    logic        blink_on;
    logic        btn_prev;
    logic        title_en;
    logic        start_edge;

    // Four-digit BCD increment that sticks at 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v == 16'h9999) begin
            return v;
        end
        for (int unsigned i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign start_edge    = start_btn_i & ~btn_prev;
    assign title_pixel_o = title_pixel_i & title_en;
    assign state_o       = state;

    // title_en is loaded with the enable for the state/blink values being entered,
    // so it always matches the registered state it accompanies.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_TITLE;
            score_o      <= '0;
            game_run_o   <= 1'b0;
            game_reset_o <= 1'b0;
            blink_on     <= 1'b1;
            frame_cnt    <= '0;
            btn_prev     <= 1'b1;
            title_en     <= 1'b1;
        end else begin
            btn_prev     <= start_btn_i;
            game_reset_o <= 1'b0;
            case (state)
                ST_TITLE: begin
                    if (start_edge) begin
                        state        <= ST_RUN;
                        game_run_o   <= 1'b1;
                        game_reset_o <= 1'b1;
                        score_o      <= '0;
                        frame_cnt    <= '0;
                        title_en     <= 1'b0;
                    end else if (frame_i) begin
                        if (frame_cnt == BLINK_LAST) begin
                            blink_on  <= ~blink_on;
                            title_en  <= ~blink_on;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (collision_i) begin
                        state      <= ST_DEAD;
                        game_run_o <= 1'b0;
                        frame_cnt  <= '0;
                        blink_on   <= 1'b1;
                        title_en   <= 1'b1;
                    end else if (frame_i) begin
                        if (frame_cnt == SCORE_LAST) begin
                            frame_cnt <= '0;
                            score_o   <= bcd_inc(score_o);
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                ST_DEAD: begin
                    if (start_edge && (frame_cnt == DEAD_LAST)) begin
                        state        <= ST_RUN;
                        game_run_o   <= 1'b1;
                        game_reset_o <= 1'b1;
                        score_o      <= '0;
                        frame_cnt    <= '0;
                        title_en     <= 1'b0;
                    end else if (frame_i && (frame_cnt != DEAD_LAST)) begin
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
                default: begin
                    state        <= ST_TITLE;
                    score_o      <= '0;
                    game_run_o   <= 1'b0;
                    game_reset_o <= 1'b0;
                    blink_on     <= 1'b1;
                    frame_cnt    <= '0;
                    title_en     <= 1'b1;
                end
            endcase
        end
    end

endmodule
